mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter sharing one 4:1-muxed datapath resource (e.g. shared memory/bus port) among 4 requesters.
- Generates registered one-hot grants and the 2-bit select that drives the downstream 4:1 mux.
- Holds ownership for a whole transaction, then rotates priority.
- Sits between requesting units and the mux/shared resource in the single-cycle core's memory/IO path.

Parameters:
- MAX_HOLD, 16: maximum cycles a single owner may hold the grant; used only when ARB_TIMEOUT_EN is defined; legal range 2..256.
- RST_PTR, 0: requester index (0..3) given highest priority after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request per requester; bit i = requester i.
- done  input  1  end-of-transaction pulse from the shared resource; meaningful only while busy=1.
- gnt  output  4  registered one-hot grant; all-zero when idle.
- sel  output  2  encoded owner index; drives the 4:1 mux select.
- busy  output  1  1 while a grant is held (state OWN).
- timeout  output  1  one-cycle pulse when an owner is forcibly released.

Behaviour:
- One clock; reset is synchronous and active-high on rst, sampled at the rising edge of clk.
- Reset values: state=IDLE, gnt=4'b0000, sel=RST_PTR, busy=0, timeout=0, ptr=RST_PTR, hold_cnt=0.
- All outputs are registered.
- Priority pointer ptr (2 bits) names the highest-priority requester. Search order: ptr, ptr+1, ptr+2, ptr+3, all mod 4 with wrap 3->0.
- State IDLE:
  - If req!=0, pick the first set bit in search order as winner w.
  - At the next edge: state=OWN, gnt=one-hot(w), sel=w, busy=1, hold_cnt=0.
  - If req==0, stay in IDLE.
  - done is ignored in IDLE.
- Grant latency: request sampled at edge N, grant visible after edge N+1 (1 cycle).
- State OWN: gnt, sel and busy are stable. Other requests wait; they are not preempted.
- Release conditions, checked each cycle in OWN:
  - (a) done=1;
  - (b) req[owner]=0 (owner withdrew);
  - (c) timeout, when the macro is enabled.
- On release, at the next edge:
  - state=IDLE, gnt=0, busy=0;
  - ptr=owner+1 mod 4;
  - sel keeps its last value.
- Mandatory one-cycle IDLE gap between owners. No two grant bits are ever set together, and no grant is ever passed straight from one owner to another.
- Simultaneous events:
  - done together with req[owner]=0: a single release; ptr advances once.
  - done together with a new req from the same owner: release anyway. The owner competes again in IDLE, now at lowest priority.
- An owner that releases and re-requests cannot win again while any other requester is pending (fairness bound: waiting at most 3 transactions).
- Reset mid-OWN: at the next edge all state returns to reset values. No timeout pulse, and ptr goes to RST_PTR.
- hold_cnt: width $clog2(MAX_HOLD). Counts cycles in OWN; saturates, no wrap.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - When hold_cnt==MAX_HOLD-1 in OWN with done=0 and req[owner]=1, force a release at the next edge.
  - timeout=1 for exactly that one cycle, alongside gnt=0.
  - ptr advances as in a normal release.
  - done and timeout on the same cycle: treated as a normal done release, timeout stays 0.
- Not defined: hold_cnt logic is absent, timeout is tied 0, and an owner holds the grant indefinitely until done or req drop.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> gnt=0000, busy=0, sel=0, timeout=0 throughout.
- req=4'b1111 constant, done pulsed 1 cycle after each grant -> grant order 0001, 0010, 0100, 1000, 0001; a 1-cycle gnt=0000 gap between each; sel=0,1,2,3,0.
- req=4'b0100 at edge N, done at edge N+4 -> gnt=0100 and sel=2 on edges N+1..N+4, gnt=0000 at N+5, ptr=3. Then req=4'b0101 -> gnt=0001 (wraps 3 to 0, requester 3 idle).
- Owner 1 granted while req=4'b0011, then req[1] dropped without done -> gnt=0000 next cycle; then gnt=0001.
- With ARB_TIMEOUT_EN and MAX_HOLD=4: req=4'b0001 held, done never -> gnt=0001 for 4 cycles, then gnt=0000 and timeout=1 for 1 cycle; then gnt=0001 again. Same stimulus with the macro undefined -> gnt=0001 held for 20+ cycles, timeout=0.
- rst=1 asserted while owner 2 busy -> next edge gnt=0000, busy=0, ptr=RST_PTR. With req=4'b1100 after reset -> gnt=0100.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between the requesters, the round-robin arbiter and the
// shared 4:1-muxed resource. The requester/resource side is the master and
// the arbiter is the slave.
interface mux4_rr_arbiter_if;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       timeout;

   modport master (
      output req,
      output done,
      input  gnt,
      input  sel,
      input  busy,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output gnt,
      output sel,
      output busy,
      output timeout
   );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for one shared 4:1-muxed resource with four requesters.
// It grants one owner for a whole transaction and forces an idle cycle between
// owners. When an owner releases, priority moves to the requester after it.
// All outputs come straight from registers.
// Optional feature: define ARB_TIMEOUT_EN to force-release an owner after
// MAX_HOLD cycles. The release pulses timeout for one cycle. Without the
// macro, timeout is held at 0 and an owner can hold the grant indefinitely.
module mux4_rr_arbiter #(
   parameter int         MAX_HOLD = 16,
   parameter logic [1:0] RST_PTR  = 2'd0
) (
   input logic               clk,
   input logic               rst,
   mux4_rr_arbiter_if.slave  bus
);

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   state_t     state_q;
   logic [3:0] gnt_q;
   logic [1:0] sel_q;
   logic [1:0] ptr_q;
   logic       busy_q;
   logic       timeout_q;

   logic [1:0] winner_d;
   logic       ownerReq;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   logic [CNT_W-1:0] holdCnt_q;
   logic             holdExpired;

   assign holdExpired = (holdCnt_q == HOLD_LAST);
`endif

   // The current owner's request bit. sel_q names the owner while in OWN.
   assign ownerReq = bus.req[sel_q];

   // Pick the first requester at or after the priority pointer, wrapping 3 -> 0.
   always_comb begin
      logic       found;
      logic [1:0] idx;
      winner_d = ptr_q;
      found    = 1'b0;
      idx      = ptr_q;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && bus.req[idx]) begin
            winner_d = idx;
            found    = 1'b1;
         end
      end
   end

   // Arbiter FSM. Grants, select, busy and the timeout pulse are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= 4'b0000;
         sel_q     <= RST_PTR;
         ptr_q     <= RST_PTR;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         holdCnt_q <= '0;
`endif
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|bus.req) begin
                  state_q <= OWN;
                  gnt_q   <= 4'b0001 << winner_d;
                  sel_q   <= winner_d;
                  busy_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                  holdCnt_q <= '0;
`endif
               end
            end
            OWN: begin
               if (bus.done || !ownerReq) begin
                  state_q <= IDLE;
                  gnt_q   <= 4'b0000;
                  busy_q  <= 1'b0;
                  ptr_q   <= sel_q + 2'd1;
               end
`ifdef ARB_TIMEOUT_EN
               else if (holdExpired) begin
                  state_q   <= IDLE;
                  gnt_q     <= 4'b0000;
                  busy_q    <= 1'b0;
                  ptr_q     <= sel_q + 2'd1;
                  timeout_q <= 1'b1;
               end else if (holdCnt_q != '1) begin
                  holdCnt_q <= holdCnt_q + 1'b1;
               end
`endif
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= 4'b0000;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.sel     = sel_q;
   assign bus.busy    = busy_q;
   assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed testbench for mux4_rr_arbiter. It covers idle after reset,
// round-robin rotation, wrap of the pointer, release by a dropped request,
// hold or timeout behaviour depending on ARB_TIMEOUT_EN, simultaneous release
// events and reset while a grant is held.
module tb_mux4_rr_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   mux4_rr_arbiter_if bus ();

   mux4_rr_arbiter #(
      .MAX_HOLD (4),
      .RST_PTR  (2'd0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic d);
      bus.req  = r;
      bus.done = d;
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] expGnt,
                              input logic [1:0] expSel, input logic expBusy,
                              input logic expTo);
      checks++;
      assert (bus.gnt === expGnt) else begin
         failures++;
         $error("[TB] FAIL %s gnt observed=%b expected=%b", tag, bus.gnt, expGnt);
      end
      checks++;
      assert (bus.sel === expSel) else begin
         failures++;
         $error("[TB] FAIL %s sel observed=%0d expected=%0d", tag, bus.sel, expSel);
      end
      checks++;
      assert (bus.busy === expBusy) else begin
         failures++;
         $error("[TB] FAIL %s busy observed=%b expected=%b", tag, bus.busy, expBusy);
      end
      checks++;
      assert (bus.timeout === expTo) else begin
         failures++;
         $error("[TB] FAIL %s timeout observed=%b expected=%b", tag, bus.timeout, expTo);
      end
   endtask

   // Directed sequence with hand-computed expectations.
   initial begin
      logic [1:0] order [5];
      checks   = 0;
      failures = 0;
      order    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

      rst = 1'b1;
      applyStimulus(4'b0000, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

      // Five idle cycles with no requests
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      end

      // All requesting; done one cycle after each grant
      applyStimulus(4'b1111, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("rr_grant", 4'b0001 << order[i], order[i], 1'b1, 1'b0);
         applyStimulus(4'b1111, 1'b1);
         tick();
         checkOutput("rr_gap", 4'b0000, order[i], 1'b0, 1'b0);
         applyStimulus(4'b1111, 1'b0);
      end
      // The pointer is now 1

      // A single requester 2 holds for four cycles, then is released by done
      applyStimulus(4'b0100, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("hold2", 4'b0100, 2'd2, 1'b1, 1'b0);
      end
      applyStimulus(4'b0100, 1'b1);
      tick();
      checkOutput("done2", 4'b0000, 2'd2, 1'b0, 1'b0);
      // The pointer is 3. Requester 3 is idle, so the search wraps to 0
      applyStimulus(4'b0101, 1'b0);
      tick();
      checkOutput("wrap0", 4'b0001, 2'd0, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      tick();
      checkOutput("wrap_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

      // The pointer is 1. Owner 1 drops its request without done
      applyStimulus(4'b0011, 1'b0);
      tick();
      checkOutput("own1", 4'b0010, 2'd1, 1'b1, 1'b0);
      applyStimulus(4'b0001, 1'b0);
      tick();
      checkOutput("drop1", 4'b0000, 2'd1, 1'b0, 1'b0);
      tick();
      checkOutput("after_drop", 4'b0001, 2'd0, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      tick();
      checkOutput("rel0", 4'b0000, 2'd0, 1'b0, 1'b0);

      // The pointer is 1. Requester 0 holds its request and done never comes
      applyStimulus(4'b0001, 1'b0);
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("to_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
      end
      tick();
      checkOutput("to_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
      tick();
      checkOutput("to_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
`else
      for (int i = 0; i < 22; i++) begin
         tick();
         checkOutput("no_to_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
      end
`endif
      applyStimulus(4'b0000, 1'b1);
      tick();
      checkOutput("to_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

      // The pointer is 1. Requester 2 is granted, then reset is asserted mid-grant
      applyStimulus(4'b0100, 1'b0);
      tick();
      checkOutput("own2", 4'b0100, 2'd2, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
      applyStimulus(4'b1100, 1'b0);
      tick();
      checkOutput("post_rst", 4'b0100, 2'd2, 1'b1, 1'b0);

      // done and a dropped request together give one release, so the pointer is 3
      applyStimulus(4'b0000, 1'b1);
      tick();
      checkOutput("dual_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
      applyStimulus(4'b1111, 1'b0);
      tick();
      checkOutput("single_adv", 4'b1000, 2'd3, 1'b1, 1'b0);

      // Owner 3 gets done while still requesting, so it drops to lowest priority
      applyStimulus(4'b1111, 1'b1);
      tick();
      checkOutput("done_rereq", 4'b0000, 2'd3, 1'b0, 1'b0);
      applyStimulus(4'b1111, 1'b0);
      tick();
      checkOutput("fair_next", 4'b0001, 2'd0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
